// File: rtl/adc_hex_framer.sv
// adc_hex_framer: on each trigger, converts NUM_CH ADC channels and streams "c:HH..,c:HH.." CR LF to a UART.
// Define ADC_HEX_FRAMER_CHECKSUM_EN to append "*HH" (XOR of the payload bytes) before CR LF.
module adc_hex_framer #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 1,
  parameter int PERIOD = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              trig,
  output logic              adc_start,
  output logic [2:0]        adc_ch,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  input  logic              tx_done,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int NDIG = DATA_W / 4;
  // Byte index within a field: 0 = channel digit, 1 = ':', 2..DIG_LAST = hex digits.
  localparam logic [3:0] DIG_LAST = 4'(NDIG + 1);
  localparam logic [3:0] MID_LAST = 4'(NDIG + 2);
`ifdef ADC_HEX_FRAMER_CHECKSUM_EN
  localparam logic [3:0] END_LAST = 4'(NDIG + 6);
`else
  localparam logic [3:0] END_LAST = 4'(NDIG + 3);
`endif
  localparam logic [2:0] CH_LAST = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_ADC, SEND, WAIT_TX, NEXT} state_t;

  state_t            state;
  state_t            state_next;
  logic [2:0]        ch;
  logic [3:0]        idx;
  logic [DATA_W-1:0] sample;
  logic              auto_trig;
  logic              start_req;
  logic              last_ch;
  logic              field_end;
  logic              adc_start_next;
  logic              tx_load_next;
  logic [3:0]        nibble;
  logic [7:0]        cur_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  generate
    if (PERIOD > 0) begin : g_auto
      localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
      logic [CW-1:0] period_cnt;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
          period_cnt <= '0;
        else if (period_cnt == CW'(PERIOD - 1))
          period_cnt <= '0;
        else
          period_cnt <= period_cnt + 1'b1;
      end

      assign auto_trig = (period_cnt == CW'(PERIOD - 1));
    end else begin : g_no_auto
      assign auto_trig = 1'b0;
    end
  endgenerate

  assign start_req = trig | auto_trig;
  assign last_ch   = (ch == CH_LAST);
  assign field_end = (idx == (last_ch ? END_LAST : MID_LAST));
  assign adc_ch    = ch;

`ifdef ADC_HEX_FRAMER_CHECKSUM_EN
  logic [7:0] csum;

  // Payload bytes (channel digits through the last data digit, commas included) feed the XOR.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      csum <= 8'h00;
    else if (state == IDLE && start_req)
      csum <= 8'h00;
    else if (state == SEND && (idx <= DIG_LAST || !last_ch))
      csum <= csum ^ cur_byte;
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_req) state_next = REQ;
      REQ:      state_next = WAIT_ADC;
      WAIT_ADC: if (adc_valid) state_next = SEND;
      SEND:     state_next = WAIT_TX;
      WAIT_TX:  if (tx_done) state_next = field_end ? NEXT : SEND;
      NEXT:     state_next = last_ch ? IDLE : REQ;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    adc_start_next = (state == REQ);
    tx_load_next   = (state == SEND);
    busy           = (state != IDLE);

    nibble = 4'h0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx == 4'(k + 2))
        nibble = sample[DATA_W-1-4*k -: 4];
    end

    cur_byte = 8'h00;
    if (idx == 4'd0)
      cur_byte = 8'h30 + {5'd0, ch};
    else if (idx == 4'd1)
      cur_byte = 8'h3A;
    else if (idx <= DIG_LAST)
      cur_byte = hex_ascii(nibble);
    else if (!last_ch)
      cur_byte = 8'h2C;
    else begin
`ifdef ADC_HEX_FRAMER_CHECKSUM_EN
      case (4'(idx - DIG_LAST))
        4'd1:    cur_byte = 8'h2A;
        4'd2:    cur_byte = hex_ascii(csum[7:4]);
        4'd3:    cur_byte = hex_ascii(csum[3:0]);
        4'd4:    cur_byte = 8'h0D;
        default: cur_byte = 8'h0A;
      endcase
`else
      cur_byte = (idx == DIG_LAST + 4'd1) ? 8'h0D : 8'h0A;
`endif
    end
  end

  // Strobes are registered one cycle behind REQ/SEND, giving the fixed 2-cycle latencies.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      adc_start <= 1'b0;
      tx_load   <= 1'b0;
      tx_data   <= 8'h00;
      ch        <= 3'd0;
      idx       <= 4'd0;
      sample    <= '0;
    end else begin
      adc_start <= adc_start_next;
      tx_load   <= tx_load_next;
      case (state)
        IDLE:     if (start_req) ch <= 3'd0;
        WAIT_ADC: if (adc_valid) begin
                    sample <= adc_data;
                    idx    <= 4'd0;
                  end
        SEND:     tx_data <= cur_byte;
        WAIT_TX:  if (tx_done && !field_end) idx <= idx + 4'd1;
        NEXT:     if (!last_ch) ch <= ch + 3'd1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      overrun <= 1'b0;
    else if (start_req && state != IDLE)
      overrun <= 1'b1;
    else if (clr_ovr)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_adc_hex_framer.sv
// Scoreboard bench for adc_hex_framer: a 12-bit/2-channel instance driven by random ADC/UART models,
// plus an 8-bit/1-channel auto-triggered instance checked against the fixed 0x3A frame.
module tb_adc_hex_framer;
  localparam int DW  = 12;
  localparam int NCH = 2;
  localparam int ND  = DW / 4;
  localparam int APER = 60;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          trig_drv = 1'b0, trig_coin = 1'b0, trig;
  logic          av_model = 1'b0, av_spur = 1'b0, adc_valid;
  logic          td_model = 1'b0, td_spur = 1'b0, tx_done;
  logic          adc_start, tx_load, busy, overrun;
  logic [2:0]    adc_ch;
  logic [DW-1:0] adc_data = '0;
  logic [7:0]    tx_data;
  logic          clr_ovr = 1'b0;
  logic          coin_en = 1'b0;

  logic          a_start, a_load, a_busy, a_ovr;
  logic [2:0]    a_ch;
  logic [7:0]    a_tx;
  logic          a_valid = 1'b0, a_done = 1'b0;

  int total = 0, bad = 0;
  int cyc = 0;
  int n_bytes = 0, n_starts = 0, n_auto = 0;
  int last_evt_cyc = 0;
  logic [7:0]    exp_q[$];
  logic [DW-1:0] forced_q[$];
  string hexs = "0123456789ABCDEF";

  assign trig      = trig_drv | trig_coin;
  assign adc_valid = av_model | av_spur;
  assign tx_done   = td_model | td_spur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_hex_framer #(.DATA_W(DW), .NUM_CH(NCH), .PERIOD(0)) dut (
    .clk(clk), .n_rst(n_rst), .trig(trig), .adc_start(adc_start), .adc_ch(adc_ch),
    .adc_valid(adc_valid), .adc_data(adc_data), .tx_data(tx_data), .tx_load(tx_load),
    .tx_done(tx_done), .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  adc_hex_framer #(.DATA_W(8), .NUM_CH(1), .PERIOD(APER)) dut_auto (
    .clk(clk), .n_rst(n_rst), .trig(1'b0), .adc_start(a_start), .adc_ch(a_ch),
    .adc_valid(a_valid), .adc_data(8'h3A), .tx_data(a_tx), .tx_load(a_load),
    .tx_done(a_done), .busy(a_busy), .overrun(a_ovr), .clr_ovr(1'b0)
  );

  // Prompt ADC/UART responders for the auto-triggered instance.
  always @(posedge clk) begin
    a_valid <= a_start;
    a_done  <= a_load;
  end

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // ADC model: chooses each sample and pushes the field bytes it must produce.
  initial begin : adc_model
    int ch_m, dly, nib;
    logic [7:0] csum_m, b;
    logic [DW-1:0] d;
    bit aborted;
    ch_m = 0;
    csum_m = 8'h00;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        ch_m = 0;
        csum_m = 8'h00;
      end else if (adc_start) begin
        n_starts++;
        $display("adc_start ch=%0d cyc=%0d", adc_ch, cyc);
        chk("adc_ch", int'(adc_ch), ch_m);
        dly = $urandom_range(0, 4);
        aborted = 1'b0;
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          if (!n_rst) aborted = 1'b1;
          else chk("adc_ch_stable", int'(adc_ch), ch_m);
        end
        if (aborted) begin
          ch_m = 0;
          csum_m = 8'h00;
        end else begin
          if (forced_q.size() > 0) d = forced_q.pop_front();
          else d = DW'($urandom);
          b = 8'h30 + 8'(ch_m); exp_q.push_back(b); csum_m ^= b;
          b = 8'h3A;            exp_q.push_back(b); csum_m ^= b;
          for (int k = 0; k < ND; k++) begin
            nib = int'((d >> (4 * (ND - 1 - k))) & DW'(15));
            b = hexs.getc(nib);
            exp_q.push_back(b);
            csum_m ^= b;
          end
          if (ch_m < NCH - 1) begin
            b = 8'h2C; exp_q.push_back(b); csum_m ^= b;
            ch_m++;
          end else begin
`ifdef ADC_HEX_FRAMER_CHECKSUM_EN
            exp_q.push_back(8'h2A);
            exp_q.push_back(hexs.getc(int'(csum_m[7:4])));
            exp_q.push_back(hexs.getc(int'(csum_m[3:0])));
`endif
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            ch_m = 0;
            csum_m = 8'h00;
          end
          adc_data = d;
          av_model = 1'b1;
          last_evt_cyc = cyc;
          @(negedge clk);
          av_model = 1'b0;
          adc_data = DW'($urandom);
        end
      end
    end
  end

  // UART model: returns tx_done after a random delay and checks tx_data holds meanwhile.
  initial begin : uart_model
    logic [7:0] held;
    int dly;
    bit aborted;
    forever begin
      @(negedge clk);
      if (n_rst && tx_load) begin
        held = tx_data;
        dly = $urandom_range(1, 4);
        aborted = 1'b0;
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          if (!n_rst) aborted = 1'b1;
        end
        if (!aborted) begin
          chk("tx_data_hold", int'(tx_data), int'(held));
          if (coin_en && held == 8'h0A) trig_coin = 1'b1;
          td_model = 1'b1;
          last_evt_cyc = cyc;
          @(negedge clk);
          td_model = 1'b0;
          trig_coin = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        exp_q.delete();
      end else if (tx_load) begin
        n_bytes++;
        $display("tx byte #%0d = 0x%02h cyc=%0d", n_bytes, tx_data, cyc);
        chk("tx_expected_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tx_data", int'(tx_data), int'(e));
        end
        chk("tx_latency", cyc - last_evt_cyc, 2);
      end
    end
  end

  // Auto-trigger instance monitor.
  initial begin : auto_mon
    logic [7:0] auto_seq[$];
    int last, ai;
`ifdef ADC_HEX_FRAMER_CHECKSUM_EN
    auto_seq = '{8'h30, 8'h3A, 8'h33, 8'h41, 8'h2A, 8'h37, 8'h38, 8'h0D, 8'h0A};
`else
    auto_seq = '{8'h30, 8'h3A, 8'h33, 8'h41, 8'h0D, 8'h0A};
`endif
    last = -1;
    ai = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        last = -1;
        ai = 0;
      end else begin
        if (a_start) begin
          if (last >= 0) begin
            chk("auto_period", cyc - last, APER);
            n_auto++;
          end
          last = cyc;
        end
        if (a_load) begin
          chk("auto_byte", int'(a_tx), int'(auto_seq[ai]));
          ai = (ai + 1) % auto_seq.size();
        end
      end
    end
  end

  task automatic start_frame();
    int t0, got;
    got = -1;
    @(negedge clk);
    trig_drv = 1'b1;
    t0 = cyc;
    @(negedge clk);
    trig_drv = 1'b0;
    chk("busy_after_trig", int'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      if (adc_start) begin
        got = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("trig_to_adc_start", got - t0, 2);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("frame_end_timeout", int'(busy), 0);
  endtask

  task automatic wait_bytes(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (n_bytes >= target) break;
      @(negedge clk);
    end
    chk("byte_wait_timeout", int'(n_bytes >= target), 1);
  endtask

  task automatic run_frame();
    int s0;
    s0 = n_starts;
    start_frame();
    wait_idle();
    repeat (2) @(negedge clk);
    chk("starts_per_frame", n_starts - s0, NCH);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("overrun_cleared", int'(overrun), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int base, s0, b0;
    repeat (3) @(negedge clk);
    chk("rst_adc_start", int'(adc_start), 0);
    chk("rst_tx_load", int'(tx_load), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_adc_ch", int'(adc_ch), 0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // Directed "0:ABC,1:005" frame.
    forced_q.push_back(12'hABC);
    forced_q.push_back(12'h005);
    run_frame();
    chk("no_overrun_clean_frame", int'(overrun), 0);

    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 8)) @(negedge clk);
      run_frame();
    end
    forced_q.push_back(12'h000);
    forced_q.push_back(12'hFFF);
    run_frame();

    // Stray handshakes while idle must be ignored.
    s0 = n_starts;
    b0 = n_bytes;
    @(negedge clk); av_spur = 1'b1;
    @(negedge clk); av_spur = 1'b0; td_spur = 1'b1;
    @(negedge clk); td_spur = 1'b0;
    repeat (5) @(negedge clk);
    chk("spurious_busy", int'(busy), 0);
    chk("spurious_bytes", n_bytes - b0, 0);
    chk("spurious_starts", n_starts - s0, 0);

    // Trigger while busy: dropped, overrun set, frame unchanged; then set-beats-clear.
    s0 = n_starts;
    base = n_bytes;
    start_frame();
    wait_bytes(base + 3);
    trig_drv = 1'b1;
    @(negedge clk);
    trig_drv = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    pulse_clr();
    wait_bytes(base + 5);
    trig_drv = 1'b1;
    clr_ovr = 1'b1;
    @(negedge clk);
    trig_drv = 1'b0;
    clr_ovr = 1'b0;
    chk("overrun_set_wins", int'(overrun), 1);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("overrun_frame_starts", n_starts - s0, NCH);
    chk("overrun_queue_drained", exp_q.size(), 0);
    chk("overrun_sticky", int'(overrun), 1);
    pulse_clr();

    // Trigger coincident with the final tx_done is dropped.
    coin_en = 1'b1;
    s0 = n_starts;
    start_frame();
    wait_idle();
    repeat (10) @(negedge clk);
    coin_en = 1'b0;
    chk("coincident_starts", n_starts - s0, NCH);
    chk("coincident_overrun", int'(overrun), 1);
    chk("coincident_busy", int'(busy), 0);

    // Reset during WAIT_TX of byte 2 aborts the frame.
    base = n_bytes;
    start_frame();
    wait_bytes(base + 2);
    n_rst = 1'b0;
    #1;
    chk("midrst_adc_start", int'(adc_start), 0);
    chk("midrst_tx_load", int'(tx_load), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_tx_data", int'(tx_data), 0);
    chk("midrst_adc_ch", int'(adc_ch), 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    s0 = n_starts;
    b0 = n_bytes;
    repeat (20) @(negedge clk);
    chk("postrst_no_bytes", n_bytes - b0, 0);
    chk("postrst_no_starts", n_starts - s0, 0);
    run_frame();

    repeat (3 * APER) @(negedge clk);
    chk("auto_periods_seen", int'(n_auto >= 2), 1);
    chk("auto_no_overrun", int'(a_ovr), 0);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
